// File: rtl/umem_arbiter.sv
// Purpose : arbitrates an instruction-fetch master (m0) and a data master (m1)
//           onto one single-ported SRAM, one transaction outstanding at a time.
// Latency : request handshake in cycle N, mem_en in N+1, rsp_valid in N+2;
//           the next handshake can happen no earlier than N+3.
// Backpressure: req_ready is offered only in IDLE and only to the winner;
//           responses cannot be stalled.
//
// Ports:
//   ACLK, ARESET                     clock, synchronous active-high reset
//   m0_req_* / m0_rsp_*              fetch read request / response
//   m1_req_* / m1_rsp_*              data read/write request / response
//   mem_en/mem_we/mem_addr/mem_wdata SRAM command; mem_rdata one cycle later
//
// Build option: define ARB_ROUND_ROBIN_EN for fair alternation between the
// masters. Left undefined, m1 has priority and a starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive fetch losses.

module umem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [XLEN-1:0] m0_req_addr,
    output logic            m0_rsp_valid,
    output logic [XLEN-1:0] m0_rsp_rdata,
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [XLEN-1:0] m1_req_addr,
    input  logic [XLEN-1:0] m1_req_wdata,
    input  logic            m1_req_we,
    input  logic [3:0]      m1_req_wstrb,
    output logic            m1_rsp_valid,
    output logic [XLEN-1:0] m1_rsp_rdata,
    output logic            mem_en,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q,    we_d;
    logic            owner_q, owner_d;   // 1: transaction belongs to m1

`ifdef ARB_ROUND_ROBIN_EN
    logic            pref_m1_q, pref_m1_d; // who wins the next tie
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0]      starve_q, starve_d;
`endif

    logic grant_m0;
    logic grant_m1;
    logic rsp_live;

    // Winner selection; only meaningful while IDLE and out of reset, so the
    // grants double as the req_ready outputs.
    always_comb begin
        grant_m0 = 1'b0;
        grant_m1 = 1'b0;
        if (state_q == ST_IDLE && !ARESET) begin
            if (m0_req_valid && m1_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (pref_m1_q) grant_m1 = 1'b1;
                else           grant_m0 = 1'b1;
`else
                if (starve_q == STARVE_MAX) grant_m0 = 1'b1;
                else                        grant_m1 = 1'b1;
`endif
            end else if (m1_req_valid) begin
                grant_m1 = 1'b1;
            end else if (m0_req_valid) begin
                grant_m0 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
        pref_m1_d = pref_m1_q;
`else
        starve_d  = starve_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_m0 || grant_m1) begin
                    state_d = ST_ACCESS;
                    owner_d = grant_m1;
                    addr_d  = grant_m1 ? m1_req_addr : m0_req_addr;
                    we_d    = grant_m1 & m1_req_we;
                    wstrb_d = grant_m1 ? m1_req_wstrb : 4'b0000;
                    wdata_d = grant_m1 ? m1_req_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    pref_m1_d = grant_m0;
`else
                    // Count only losses where fetch was actually waiting.
                    if (grant_m0) begin
                        starve_d = 4'd0;
                    end else if (m0_req_valid && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
`endif
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            pref_m1_q <= 1'b1;
`else
            starve_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            pref_m1_q <= pref_m1_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    assign m0_req_ready = grant_m0;
    assign m1_req_ready = grant_m1;

    // Outputs are masked by ARESET so nothing escapes while reset is held,
    // including a transaction caught mid-flight.
    assign mem_en    = (state_q == ST_ACCESS) && !ARESET;
    assign mem_we    = (mem_en && we_q) ? wstrb_q : 4'b0000;
    assign mem_addr  = addr_q & WORD_MASK;
    assign mem_wdata = wdata_q;

    assign rsp_live     = (state_q == ST_RESP) && !ARESET;
    assign m0_rsp_valid = rsp_live && !owner_q;
    assign m1_rsp_valid = rsp_live && owner_q;
    // Writes are acknowledged with zero data.
    assign m0_rsp_rdata = (m0_rsp_valid && !we_q) ? mem_rdata : '0;
    assign m1_rsp_rdata = (m1_rsp_valid && !we_q) ? mem_rdata : '0;

endmodule
